interboard_link_gen2: RTL and testbench
=======================================

INTERBOARD_LINK_GEN2 -- requirements
Module: interboard_link_gen2

Interface
REQ-001 Parameter DATA_W, default 6, width of one link word (inter_data_in/out).
REQ-002 Parameter MSG_WORDS, default 4, words per message (>=1).
REQ-003 Parameter FIFO_DEPTH, default 4, TX message queue depth, power of two >=2.
REQ-004 Parameter TIMEOUT_CYC, default 1000000, handshake timeout in clk cycles (>=8).
REQ-005 Port clk input 1: single clock; all logic rising-edge.
REQ-006 Port rst input 1: reset, synchronous, active-high.
REQ-007 Port tx_valid input 1: local message offered.
REQ-008 Port tx_msg input DATA_W*MSG_WORDS: message; word k = bits [k*DATA_W +: DATA_W].
REQ-009 Port tx_ready output 1: queue can accept (not full).
REQ-010 Port Request_out output 1 / Ack_out output 1 / inter_data_out output DATA_W: link to peer.
REQ-011 Port Request_in input 1 / Ack_in input 1 / inter_data_in input DATA_W: link from peer, asynchronous.
REQ-012 Port rx_valid output 1: one-cycle pulse, complete message in rx_msg.
REQ-013 Port rx_msg output DATA_W*MSG_WORDS: last received message, same word order as tx_msg.
REQ-014 Port link_err output 1: one-cycle pulse on any timeout abort.
REQ-015 Port err_cnt output 8: timeout abort count, saturating at 255.

Function
REQ-016 TX and RX paths SHALL be independent (full duplex); simultaneous traffic in both directions legal.
REQ-017 Request_in, Ack_in, inter_data_in SHALL each pass a 2-flop synchronizer; logic uses only synchronized versions.
REQ-018 Message accepted when tx_valid && tx_ready at a rising edge; push into FIFO; tx_ready = !full, registered-state combinational.
REQ-019 Push and pop on same edge with FIFO full SHALL succeed (count unchanged); pointers wrap modulo FIFO_DEPTH.
REQ-020 TX FSM: IDLE -> SETUP (pop, drive word 0 on inter_data_out) -> REQ (Request_out=1, wait ack_sync=1) -> REL (Request_out=0, wait ack_sync=0) -> SETUP next word, or IDLE after word MSG_WORDS-1.
REQ-021 inter_data_out SHALL be stable from SETUP through end of REL for that word.
REQ-022 Latency: message accepted into empty FIFO with TX IDLE at edge t -> SETUP at t+1 -> Request_out high at t+2.
REQ-023 RX FSM: WAIT_REQ (Ack_out=0; on req_sync=1 capture data_sync into word slot idx) -> ACK (Ack_out=1, wait req_sync=0) -> WAIT_REQ, idx+1.
REQ-024 On capture of word MSG_WORDS-1: rx_msg updated and rx_valid pulsed the next cycle; idx returns to 0; rx_msg otherwise holds.
REQ-025 TX timeout: a counter SHALL run in REQ and REL, clear on state change; at TIMEOUT_CYC cycles -> Request_out=0, current message dropped, TX to IDLE, link_err pulse, err_cnt+1.
REQ-026 After TX timeout, TX SHALL wait for ack_sync=0 before leaving IDLE.
REQ-027 RX timeout: in ACK, or in WAIT_REQ with idx!=0, for TIMEOUT_CYC cycles -> partial message discarded, idx=0, Ack_out=0, RX to WAIT_REQ, link_err pulse, err_cnt+1.
REQ-028 TX and RX timeout in same cycle: one link_err pulse, err_cnt +2, saturating.
REQ-029 Queued messages SHALL transmit in FIFO order with no word interleaving.

Reset
REQ-030 rst SHALL, on next edge, force: FIFO empty, tx_ready=1, both FSMs idle, idx=0, Request_out=0, Ack_out=0, inter_data_out=0, rx_valid=0, rx_msg=0, link_err=0, err_cnt=0, synchronizers 0.
REQ-031 rst mid-message SHALL abort both directions without rx_valid or link_err.

Verification
REQ-032 Loopback (outputs tied to own inputs), defaults: send 24'hABC123 -> exactly one rx_valid, rx_msg=24'hABC123, link_err never.
REQ-033 Loopback: push 5 messages back-to-back (0x000001..0x000005) with FIFO_DEPTH=4 -> tx_ready low after 4th until first pop; all 5 received in order.
REQ-034 Ack_in held 0, TIMEOUT_CYC=16 -> Request_out drops 16 cycles after REQ entry, link_err pulses once, err_cnt=1, queued next message then sends normally once loopback restored.
REQ-035 Peer sends 2 words then stops, TIMEOUT_CYC=16 -> partial discarded, err_cnt=1; next full message 24'h0F0F0F received correctly.
REQ-036 Two instances cross-connected, both send simultaneously (24'h111111 / 24'h222222) -> each receives the other's message, one rx_valid each.
REQ-037 Assert rst while TX in REQ on word 2 -> Request_out=0 next cycle, all outputs at reset values, err_cnt=0.

Source files
------------

// File: rtl/interboard_link_gen2.sv
// -----------------------------------------------------------------------------
// interboard_link_gen2
//
// Full-duplex board-to-board message link built on a 4-phase req/ack
// handshake. Each message of MSG_WORDS words of DATA_W bits is queued locally,
// then sent one word at a time. A word is placed on inter_data_out and then
// qualified with Request_out, and the peer acknowledges it on Ack_in. The
// receive side mirrors this: it captures inter_data_in when Request_in rises
// and answers with Ack_out. Both directions run independently. Both have a
// handshake watchdog that aborts a stalled transfer.
//
// Ports
//   clk             single clock, all logic on the rising edge
//   rst             synchronous, active-high reset
//   tx_valid        local message offered
//   tx_msg          message to send; word k = tx_msg[k*DATA_W +: DATA_W]
//   tx_ready        TX queue can accept a message (queue not full)
//   Request_out     word-valid strobe to the peer
//   Ack_out         acknowledge to the peer for a captured word
//   inter_data_out  current outgoing word
//   Request_in      peer word-valid strobe (asynchronous)
//   Ack_in          peer acknowledge (asynchronous)
//   inter_data_in   peer word (asynchronous, qualified by Request_in)
//   rx_valid        one-cycle pulse: rx_msg holds a new complete message
//   rx_msg          last complete received message, same word order as tx_msg
//   link_err        one-cycle pulse on any handshake timeout abort
//   err_cnt         number of timeout aborts, saturating at 255
// -----------------------------------------------------------------------------
module interboard_link_gen2 #(
  parameter int DATA_W      = 6,
  parameter int MSG_WORDS   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [DATA_W*MSG_WORDS-1:0] tx_msg,
  output logic                        tx_ready,
  output logic                        Request_out,
  output logic                        Ack_out,
  output logic [DATA_W-1:0]           inter_data_out,
  input  logic                        Request_in,
  input  logic                        Ack_in,
  input  logic [DATA_W-1:0]           inter_data_in,
  output logic                        rx_valid,
  output logic [DATA_W*MSG_WORDS-1:0] rx_msg,
  output logic                        link_err,
  output logic [7:0]                  err_cnt
);

  localparam int MSG_W = DATA_W * MSG_WORDS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_REQ,
    TX_REL
  } tx_state_e;

  typedef enum logic {
    RX_WAIT,
    RX_ACK
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers: only the *_sync_q copies are used by the logic.
  // ---------------------------------------------------------------------------
  logic              req_meta_q, req_sync_q;
  logic              ack_meta_q, ack_sync_q;
  logic [DATA_W-1:0] data_meta_q, data_sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta_q  <= 1'b0;
      req_sync_q  <= 1'b0;
      ack_meta_q  <= 1'b0;
      ack_sync_q  <= 1'b0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      req_meta_q  <= Request_in;
      req_sync_q  <= req_meta_q;
      ack_meta_q  <= Ack_in;
      ack_sync_q  <= ack_meta_q;
      data_meta_q <= inter_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // TX message queue
  // ---------------------------------------------------------------------------
  logic [MSG_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;

  assign fifo_full  = (fifo_cnt_q == DEPTH_C);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_push  = tx_valid && !fifo_full;
  assign tx_ready   = !fifo_full;

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= tx_msg;
  end

  // Pointers wrap naturally because the depth is a power of two. A push and
  // a pop on the same edge leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX handshake FSM
  // ---------------------------------------------------------------------------
  tx_state_e         tx_state_q, tx_state_d;
  logic [IDX_W-1:0]  tx_word_q, tx_word_d;
  logic [MSG_W-1:0]  tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [TMO_W-1:0]  tx_tmo_q, tx_tmo_d;
  logic              req_out_q;
  logic              tx_tmo_hit;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_word_d  = tx_word_q;
    tx_buf_d   = tx_buf_q;
    data_out_d = data_out_q;
    tx_tmo_d   = '0;
    tx_tmo_hit = 1'b0;
    fifo_pop   = 1'b0;

    case (tx_state_q)
      // A new message starts only once the peer's ack is low. After a timeout
      // abort, this keeps a late ack from being taken as the ack for word 0.
      TX_IDLE: begin
        if (!fifo_empty && !ack_sync_q) begin
          fifo_pop   = 1'b1;
          tx_buf_d   = fifo_mem_q[rd_ptr_q];
          tx_word_d  = '0;
          data_out_d = fifo_mem_q[rd_ptr_q][DATA_W-1:0];
          tx_state_d = TX_SETUP;
        end
      end

      // One cycle with data stable on the wire before Request_out rises.
      TX_SETUP: tx_state_d = TX_REQ;

      TX_REQ: begin
        if (tx_tmo_q == TMO_LAST) begin
          tx_tmo_hit = 1'b1;
          tx_state_d = TX_IDLE;
        end else if (ack_sync_q) begin
          tx_state_d = TX_REL;
        end else begin
          tx_tmo_d = tx_tmo_q + 1'b1;
        end
      end

      TX_REL: begin
        if (tx_tmo_q == TMO_LAST) begin
          tx_tmo_hit = 1'b1;
          tx_state_d = TX_IDLE;
        end else if (!ack_sync_q) begin
          if (tx_word_q == LAST_IDX) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_word_d  = tx_word_q + 1'b1;
            data_out_d = tx_buf_q[int'(tx_word_d)*DATA_W +: DATA_W];
            tx_state_d = TX_SETUP;
          end
        end else begin
          tx_tmo_d = tx_tmo_q + 1'b1;
        end
      end

      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX handshake FSM
  // ---------------------------------------------------------------------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic [MSG_W-1:0] rx_buf_q, rx_buf_d;
  logic [MSG_W-1:0] rx_msg_q, rx_msg_d;
  logic [TMO_W-1:0] rx_tmo_q, rx_tmo_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ack_out_q;
  logic             rx_tmo_hit;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_buf_d   = rx_buf_q;
    rx_msg_d   = rx_msg_q;
    rx_valid_d = 1'b0;
    rx_tmo_d   = '0;
    rx_tmo_hit = 1'b0;

    case (rx_state_q)
      RX_WAIT: begin
        if (req_sync_q) begin
          rx_buf_d[int'(rx_idx_q)*DATA_W +: DATA_W] = data_sync_q;
          rx_state_d = RX_ACK;
          if (rx_idx_q == LAST_IDX) begin
            rx_msg_d   = rx_buf_d;
            rx_valid_d = 1'b1;
            rx_idx_d   = '0;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end else if (rx_idx_q != '0) begin
          // Mid-message gap: the peer must deliver the next word in time.
          if (rx_tmo_q == TMO_LAST) begin
            rx_tmo_hit = 1'b1;
            rx_idx_d   = '0;
          end else begin
            rx_tmo_d = rx_tmo_q + 1'b1;
          end
        end
      end

      RX_ACK: begin
        if (!req_sync_q) begin
          rx_state_d = RX_WAIT;
        end else if (rx_tmo_q == TMO_LAST) begin
          rx_tmo_hit = 1'b1;
          rx_idx_d   = '0;
          rx_state_d = RX_WAIT;
        end else begin
          rx_tmo_d = rx_tmo_q + 1'b1;
        end
      end

      default: rx_state_d = RX_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error accounting: simultaneous TX and RX aborts share one link_err pulse
  // but both count.
  // ---------------------------------------------------------------------------
  logic       link_err_q;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 9'(tx_tmo_hit) + 9'(rx_tmo_hit);
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_word_q  <= '0;
      tx_buf_q   <= '0;
      data_out_q <= '0;
      tx_tmo_q   <= '0;
      req_out_q  <= 1'b0;
      rx_state_q <= RX_WAIT;
      rx_idx_q   <= '0;
      rx_buf_q   <= '0;
      rx_msg_q   <= '0;
      rx_tmo_q   <= '0;
      rx_valid_q <= 1'b0;
      ack_out_q  <= 1'b0;
      link_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_word_q  <= tx_word_d;
      tx_buf_q   <= tx_buf_d;
      data_out_q <= data_out_d;
      tx_tmo_q   <= tx_tmo_d;
      // Strobes are registered decodes of the next state, so they are glitch
      // free on the wire and change on the same edge as the state.
      req_out_q  <= (tx_state_d == TX_REQ);
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_buf_q   <= rx_buf_d;
      rx_msg_q   <= rx_msg_d;
      rx_tmo_q   <= rx_tmo_d;
      rx_valid_q <= rx_valid_d;
      ack_out_q  <= (rx_state_d == RX_ACK);
      link_err_q <= tx_tmo_hit | rx_tmo_hit;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign Request_out    = req_out_q;
  assign Ack_out        = ack_out_q;
  assign inter_data_out = data_out_q;
  assign rx_valid       = rx_valid_q;
  assign rx_msg         = rx_msg_q;
  assign link_err       = link_err_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_interboard_link_gen2.sv
// -----------------------------------------------------------------------------
// tb_interboard_link_gen2
//
// Directed bench for interboard_link_gen2. The main DUT's link inputs are
// steered by 'mode': its own outputs (loopback), bench-driven peer signals
// (manual), or a second instance (peer). Expected received messages are
// queued when stimulus is applied and popped whenever rx_valid pulses.
// -----------------------------------------------------------------------------
module tb_interboard_link_gen2;

  localparam int DW   = 6;
  localparam int MW   = 4;
  localparam int MSGW = DW * MW;
  localparam int TMO  = 16;

  typedef enum logic [1:0] {M_LOOP, M_MANUAL, M_PEER} mode_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  mode_e           mode;

  logic            tx_valid, tx_ready;
  logic [MSGW-1:0] tx_msg, rx_msg;
  logic            req_o, ack_o, req_i, ack_i;
  logic [DW-1:0]   dout, din;
  logic            rx_valid, link_err;
  logic [7:0]      err_cnt;

  logic            p_tx_valid, p_tx_ready;
  logic [MSGW-1:0] p_tx_msg, p_rx_msg;
  logic            p_req_o, p_ack_o, p_req_i, p_ack_i;
  logic [DW-1:0]   p_dout, p_din;
  logic            p_rx_valid, p_link_err;
  logic [7:0]      p_err_cnt;

  logic            m_req, m_ack;
  logic [DW-1:0]   m_data;

  assign req_i = (mode == M_LOOP) ? req_o : (mode == M_PEER) ? p_req_o : m_req;
  assign ack_i = (mode == M_LOOP) ? ack_o : (mode == M_PEER) ? p_ack_o : m_ack;
  assign din   = (mode == M_LOOP) ? dout  : (mode == M_PEER) ? p_dout  : m_data;

  assign p_req_i = (mode == M_PEER) ? req_o : 1'b0;
  assign p_ack_i = (mode == M_PEER) ? ack_o : 1'b0;
  assign p_din   = (mode == M_PEER) ? dout  : '0;

  interboard_link_gen2 #(.DATA_W(DW), .MSG_WORDS(MW), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_msg(tx_msg), .tx_ready(tx_ready),
    .Request_out(req_o), .Ack_out(ack_o), .inter_data_out(dout),
    .Request_in(req_i), .Ack_in(ack_i), .inter_data_in(din),
    .rx_valid(rx_valid), .rx_msg(rx_msg), .link_err(link_err), .err_cnt(err_cnt)
  );

  interboard_link_gen2 #(.DATA_W(DW), .MSG_WORDS(MW), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) peer (
    .clk(clk), .rst(rst),
    .tx_valid(p_tx_valid), .tx_msg(p_tx_msg), .tx_ready(p_tx_ready),
    .Request_out(p_req_o), .Ack_out(p_ack_o), .inter_data_out(p_dout),
    .Request_in(p_req_i), .Ack_in(p_ack_i), .inter_data_in(p_din),
    .rx_valid(p_rx_valid), .rx_msg(p_rx_msg), .link_err(p_link_err), .err_cnt(p_err_cnt)
  );

  int n_vec     = 0;
  int n_fail    = 0;
  int rx_cnt    = 0;
  int p_rx_cnt  = 0;
  int lerr_seen = 0;

  logic [MSGW-1:0] exp_q[$];
  logic [MSGW-1:0] p_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    logic [MSGW-1:0] e;
    @(posedge clk);
    #1;
    if (link_err || p_link_err) lerr_seen++;
    if (rx_valid) begin
      rx_cnt++;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 'x;
      check("rx_msg", 32'(rx_msg), 32'(e));
    end
    if (p_rx_valid) begin
      p_rx_cnt++;
      if (p_exp_q.size() != 0) e = p_exp_q.pop_front();
      else                     e = 'x;
      check("peer_rx_msg", 32'(p_rx_msg), 32'(e));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || p_exp_q.size() != 0); i++) tick();
    check("drain_empty", 32'(exp_q.size() + p_exp_q.size()), 32'd0);
    exp_q.delete();
    p_exp_q.delete();
    repeat (20) tick();
  endtask

  // Bench acting as the far-end transmitter for one word.
  task automatic peer_word(input logic [DW-1:0] w);
    int n;
    m_data = w;
    tick();
    tick();
    m_req = 1'b1;
    n = 0;
    while (!ack_o && n < 50) begin tick(); n++; end
    check("peer_ack_hi", 32'(ack_o), 32'd1);
    m_req = 1'b0;
    n = 0;
    while (ack_o && n < 50) begin tick(); n++; end
    check("peer_ack_lo", 32'(ack_o), 32'd0);
  endtask

  initial begin
    logic [MSGW-1:0] msg;
    int n, base, p_base, base_err;

    rst = 1'b1; mode = M_MANUAL;
    tx_valid = 1'b0; tx_msg = '0; p_tx_valid = 1'b0; p_tx_msg = '0;
    m_req = 1'b0; m_ack = 1'b0; m_data = '0;
    repeat (3) tick();

    // Reset state
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_req_out",  32'(req_o),    32'd0);
    check("rst_ack_out",  32'(ack_o),    32'd0);
    check("rst_data_out", 32'(dout),     32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_msg",   32'(rx_msg),   32'd0);
    check("rst_link_err", 32'(link_err), 32'd0);
    check("rst_err_cnt",  32'(err_cnt),  32'd0);
    rst = 1'b0;
    tick();

    // Loopback single message, with TX start latency
    mode = M_LOOP;
    msg  = 24'hABC123;
    base = rx_cnt;
    exp_q.push_back(msg);
    tx_valid = 1'b1; tx_msg = msg;
    tick();
    tx_valid = 1'b0;
    check("lat_t0_req", 32'(req_o), 32'd0);
    tick();
    check("lat_t1_req",  32'(req_o), 32'd0);
    check("lat_t1_data", 32'(dout),  32'(msg[DW-1:0]));
    tick();
    check("lat_t2_req", 32'(req_o), 32'd1);
    drain();
    check("loop_rx_once", 32'(rx_cnt - base), 32'd1);
    check("loop_no_err",  32'(lerr_seen),     32'd0);

    // Five back-to-back pushes while the peer stalls, then loopback drains.
    mode = M_MANUAL;
    for (int i = 0; i < 5; i++) begin
      check("fill_ready", 32'(tx_ready), 32'd1);
      tx_valid = 1'b1;
      tx_msg   = MSGW'(i + 1);
      exp_q.push_back(MSGW'(i + 1));
      tick();
    end
    tx_valid = 1'b0;
    check("full_ready_lo", 32'(tx_ready), 32'd0);
    tick();
    check("full_ready_hold", 32'(tx_ready), 32'd0);
    mode = M_LOOP;
    n = 0;
    while (!tx_ready && n < 100) begin tick(); n++; end
    check("full_ready_back", 32'(tx_ready), 32'd1);
    drain();
    check("fill_err_cnt", 32'(err_cnt), 32'd0);

    // TX timeout with Ack_in held low; the next queued message then goes out.
    mode = M_MANUAL;
    base_err = lerr_seen;
    tx_valid = 1'b1; tx_msg = 24'h5A5A5A;
    tick();
    tx_msg = 24'h0F1E2D;
    exp_q.push_back(24'h0F1E2D);
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!req_o && n < 50) begin tick(); n++; end
    check("tmo_req_rise", 32'(req_o), 32'd1);
    n = 0;
    while (req_o && n < 100) begin tick(); n++; end
    check("tmo_req_width", 32'(n),        32'(TMO));
    check("tmo_link_err",  32'(link_err), 32'd1);
    check("tmo_err_cnt",   32'(err_cnt),  32'd1);
    mode = M_LOOP;
    drain();
    check("tmo_one_pulse", 32'(lerr_seen - base_err), 32'd1);

    // RX timeout: peer sends two words then stops; next full message is good.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = M_MANUAL;
    base_err = lerr_seen;
    msg = 24'h3F0041;
    peer_word(msg[0 +: DW]);
    peer_word(msg[DW +: DW]);
    n = 0;
    while (lerr_seen == base_err && n < 100) begin tick(); n++; end
    check("rxtmo_pulse",   32'(lerr_seen - base_err), 32'd1);
    check("rxtmo_err_cnt", 32'(err_cnt), 32'd1);
    check("rxtmo_ack_lo",  32'(ack_o),   32'd0);
    msg = 24'h0F0F0F;
    exp_q.push_back(msg);
    for (int k = 0; k < MW; k++) peer_word(msg[k*DW +: DW]);
    drain();
    check("rxtmo_rx_msg",    32'(rx_msg),  32'h0F0F0F);
    check("rxtmo_cnt_final", 32'(err_cnt), 32'd1);

    // Two instances cross-connected, sending simultaneously.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = M_PEER;
    base = rx_cnt; p_base = p_rx_cnt; base_err = lerr_seen;
    exp_q.push_back(24'h222222);
    p_exp_q.push_back(24'h111111);
    tx_valid = 1'b1;   tx_msg = 24'h111111;
    p_tx_valid = 1'b1; p_tx_msg = 24'h222222;
    tick();
    tx_valid = 1'b0; p_tx_valid = 1'b0;
    drain();
    check("duplex_rx_once",   32'(rx_cnt - base),        32'd1);
    check("duplex_p_rx_once", 32'(p_rx_cnt - p_base),    32'd1);
    check("duplex_no_err",    32'(lerr_seen - base_err), 32'd0);
    check("duplex_p_err_cnt", 32'(p_err_cnt),            32'd0);
    check("duplex_p_ready",   32'(p_tx_ready),           32'd1);

    // Reset while TX holds Request_out on word 2.
    mode = M_LOOP;
    msg  = 24'h3C3C3C;
    tx_valid = 1'b1; tx_msg = msg;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!(req_o && dout == msg[2*DW +: DW]) && n < 300) begin tick(); n++; end
    check("mid_w2_req", 32'(req_o), 32'd1);
    base = rx_cnt; base_err = lerr_seen;
    rst = 1'b1;
    tick();
    check("mid_rst_req",      32'(req_o),    32'd0);
    check("mid_rst_ack",      32'(ack_o),    32'd0);
    check("mid_rst_data",     32'(dout),     32'd0);
    check("mid_rst_ready",    32'(tx_ready), 32'd1);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_rx_msg",   32'(rx_msg),   32'd0);
    check("mid_rst_link_err", 32'(link_err), 32'd0);
    check("mid_rst_err_cnt",  32'(err_cnt),  32'd0);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    check("mid_rst_no_rx",  32'(rx_cnt - base),        32'd0);
    check("mid_rst_no_err", 32'(lerr_seen - base_err), 32'd0);
    check("mid_rst_quiet",  32'(req_o),                32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
